// File: rtl/spi_pkg.sv
// Shared definitions for the SPI sample sequencer: FSM encoding, period math and
// the elaboration-time parameter check macro.
`ifndef SPI_PKG_SV
`define SPI_PKG_SV

// Elaboration error when cond_ is false; label_ names the generate block.
`define SPI_PARAM_CHECK(cond_, label_) \
  if (!(cond_)) begin : label_ \
    $error("spi_sample_sequencer: illegal parameter combination"); \
  end

package spi_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRequest = 2'd1,
    StBusy    = 2'd2
  } seq_state_e;

  function automatic int unsigned calc_period(input int unsigned clk_hz,
                                              input int unsigned rate_hz);
    return clk_hz / rate_hz;
  endfunction

endpackage

`endif

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output; push while full is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  `SPI_PARAM_CHECK(DEPTH >= 2 && (DEPTH & (DEPTH - 1)) == 0, g_depth_chk)

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             do_push, do_pop;

  assign valid_o = (level_q != '0);
  assign full_o  = (level_q == LvlW'(DEPTH));
  assign level_o = level_q;
  assign data_o  = mem_q[rptr_q];

  always_comb begin
    do_pop  = pop_i && valid_o;
    do_push = push_i && (!full_o || do_pop);
    wptr_d  = do_push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = do_pop ? rptr_q + PtrW'(1) : rptr_q;
    level_d = level_q + LvlW'(do_push) - LvlW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage is not reset; pointer reset alone discards the contents.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/spi_sample_sequencer.sv
// Periodic quick_spi request generator with capture FIFO and miss/drop detection.
// Optional saturating drop counter enabled by defining SEQ_DROP_COUNT_EN.
module spi_sample_sequencer
  import spi_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ     = 100000000,
  parameter int unsigned SAMPLE_RATE_HZ  = 1000000,
  parameter int unsigned MAX_DATA_LENGTH = 16,
  parameter int unsigned NUM_DEVICES     = 1,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_n_i,
  input  logic                                   enable_i,
  input  logic [$clog2(MAX_DATA_LENGTH)-1:0]     num_data_i,
  input  logic [MAX_DATA_LENGTH*NUM_DEVICES-1:0] tx_data_i,
  output logic                                   spi_request_o,
  output logic [$clog2(MAX_DATA_LENGTH)-1:0]     spi_num_data_o,
  output logic [MAX_DATA_LENGTH*NUM_DEVICES-1:0] spi_data_o,
  input  logic                                   spi_cs_n_i,
  input  logic [MAX_DATA_LENGTH*NUM_DEVICES-1:0] spi_data_i,
  input  logic                                   spi_data_valid_i,
  output logic                                   m_valid_o,
  input  logic                                   m_ready_i,
  output logic [MAX_DATA_LENGTH*NUM_DEVICES-1:0] m_data_o,
  output logic [$clog2(FIFO_DEPTH):0]            fifo_level_o,
  output logic                                   missed_tick_o,
  output logic                                   dropped_o,
  output logic [15:0]                            drop_count_o
);

  localparam int unsigned Period = calc_period(CLK_FREQ_HZ, SAMPLE_RATE_HZ);
  localparam int unsigned CntW   = (Period > 1) ? $clog2(Period) : 1;
  localparam int unsigned NdW    = $clog2(MAX_DATA_LENGTH);
  localparam int unsigned DataW  = MAX_DATA_LENGTH * NUM_DEVICES;

  `SPI_PARAM_CHECK(Period >= 2, g_period_chk)

  seq_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             req_q, req_d;
  logic [NdW-1:0]   num_q, num_d;
  logic [DataW-1:0] txd_q, txd_d;
  logic             missed_q, missed_d;
  logic             dropped_q, dropped_d;
  logic             tick, push, pop, fifo_full;

  assign tick = enable_i && (cnt_q == CntW'(Period - 1));
  assign pop  = m_valid_o && m_ready_i;

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (!enable_i || tick) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    num_d     = num_q;
    txd_d     = txd_q;
    push      = 1'b0;
    dropped_d = 1'b0;
    missed_d  = tick && (state_q != StIdle);
    case (state_q)
      StIdle: begin
        if (tick) begin
          num_d   = num_data_i;
          txd_d   = tx_data_i;
          req_d   = 1'b1;
          state_d = StRequest;
        end
      end
      StRequest: begin
        // Request is held until quick_spi acknowledges by asserting chip select.
        if (!spi_cs_n_i) begin
          req_d   = 1'b0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (spi_data_valid_i) begin
          if (fifo_full && !pop) begin
            dropped_d = 1'b1;
          end else begin
            push = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      num_q     <= '0;
      txd_q     <= '0;
      missed_q  <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      num_q     <= num_d;
      txd_q     <= txd_d;
      missed_q  <= missed_d;
      dropped_q <= dropped_d;
    end
  end

  assign spi_request_o  = req_q;
  assign spi_num_data_o = num_q;
  assign spi_data_o     = txd_q;
  assign missed_tick_o  = missed_q;
  assign dropped_o      = dropped_q;

  sync_fifo #(
    .WIDTH(DataW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .push_i (push),
    .data_i (spi_data_i),
    .pop_i  (pop),
    .data_o (m_data_o),
    .valid_o(m_valid_o),
    .full_o (fifo_full),
    .level_o(fifo_level_o)
  );

`ifdef SEQ_DROP_COUNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [16:0] drop_sum;

  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + 17'(missed_q) + 17'(dropped_q);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count_o = drop_cnt_q;
`else
  assign drop_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_spi_sample_sequencer.sv
// Directed bench for spi_sample_sequencer with a cycle-level quick_spi responder.
module tb_spi_sample_sequencer;

`ifdef SEQ_DROP_COUNT_EN
  localparam int DropOn = 1;
`else
  localparam int DropOn = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [3:0]  num_data;
  logic [15:0] tx_data;
  logic        spi_request_o;
  logic [3:0]  spi_num_data_o;
  logic [15:0] spi_data_o;
  logic        spi_cs_n;
  logic [15:0] spi_data;
  logic        spi_valid;
  logic        m_valid_o;
  logic        m_ready;
  logic [15:0] m_data_o;
  logic [2:0]  fifo_level_o;
  logic        missed_tick_o;
  logic        dropped_o;
  logic [15:0] drop_count_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Responder controls, owned by the main initial block.
  int          cs_delay    = 3;
  int          valid_delay = 40;
  bit          model_inc   = 1'b0;
  logic [15:0] set_val     = 16'hA5C3;
  bit          set_req     = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_sample_sequencer dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .enable_i        (enable),
    .num_data_i      (num_data),
    .tx_data_i       (tx_data),
    .spi_request_o   (spi_request_o),
    .spi_num_data_o  (spi_num_data_o),
    .spi_data_o      (spi_data_o),
    .spi_cs_n_i      (spi_cs_n),
    .spi_data_i      (spi_data),
    .spi_data_valid_i(spi_valid),
    .m_valid_o       (m_valid_o),
    .m_ready_i       (m_ready),
    .m_data_o        (m_data_o),
    .fifo_level_o    (fifo_level_o),
    .missed_tick_o   (missed_tick_o),
    .dropped_o       (dropped_o),
    .drop_count_o    (drop_count_o)
  );

  // quick_spi stand-in: acks with cs_n low, then strobes one word; unaffected by DUT reset.
  initial begin : responder
    int          mst;
    int          mcnt;
    bit          seen;
    logic [15:0] word;
    mst = 0; mcnt = 0; seen = 1'b0; word = 16'hA5C3;
    spi_cs_n = 1'b1; spi_valid = 1'b0; spi_data = '0;
    forever begin
      @(posedge clk); #1;
      if (set_req != seen) begin
        word = set_val;
        seen = set_req;
      end
      case (mst)
        0: if (spi_request_o) begin mcnt = 0; mst = 1; end
        1: begin
          mcnt++;
          if (mcnt >= cs_delay) begin spi_cs_n = 1'b0; mcnt = 0; mst = 2; end
        end
        2: begin
          mcnt++;
          if (mcnt >= valid_delay) begin
            spi_valid = 1'b1;
            spi_data  = word;
            if (model_inc) word = word + 16'd1;
            mst = 3;
          end
        end
        default: begin spi_valid = 1'b0; spi_cs_n = 1'b1; mst = 0; end
      endcase
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic wait_req_rise(input int budget, output bit ok, output int at);
    bit prev;
    ok = 1'b0; at = 0; prev = spi_request_o;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (spi_request_o && !prev) begin ok = 1'b1; at = cyc; return; end
      prev = spi_request_o;
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (spi_valid) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0;
    num_data = 4'hF; tx_data = 16'h1234;
    repeat (3) @(negedge clk);
    n_cmp++; if (spi_request_o !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", spi_request_o); end
    n_cmp++; if (spi_num_data_o !== 4'h0) begin n_bad++; $display("FAIL rst_num got %h want 0", spi_num_data_o); end
    n_cmp++; if (spi_data_o !== 16'h0) begin n_bad++; $display("FAIL rst_data got %h want 0", spi_data_o); end
    n_cmp++; if (m_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_mvalid got %b want 0", m_valid_o); end
    n_cmp++; if (fifo_level_o !== 3'd0) begin n_bad++; $display("FAIL rst_level got %0d want 0", fifo_level_o); end
    n_cmp++; if (missed_tick_o !== 1'b0) begin n_bad++; $display("FAIL rst_missed got %b want 0", missed_tick_o); end
    n_cmp++; if (dropped_o !== 1'b0) begin n_bad++; $display("FAIL rst_dropped got %b want 0", dropped_o); end
    n_cmp++; if (drop_count_o !== 16'h0) begin n_bad++; $display("FAIL rst_dcnt got %h want 0", drop_count_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    int t0, t1, t2;
    @(negedge clk);
    enable = 1'b1; m_ready = 1'b1; t0 = cyc;
    wait_req_rise(200, ok, t1);
    n_cmp++; if (!ok || (t1 - t0) != 100) begin n_bad++; $display("FAIL first_req latency got %0d want 100 (ok=%0b)", t1 - t0, ok); end
    n_cmp++; if (spi_data_o !== 16'h1234) begin n_bad++; $display("FAIL latch_data got %h want 1234", spi_data_o); end
    n_cmp++; if (spi_num_data_o !== 4'hF) begin n_bad++; $display("FAIL latch_num got %h want f", spi_num_data_o); end
    tx_data = 16'h5678;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (spi_cs_n === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (!ok || spi_request_o !== 1'b1) begin n_bad++; $display("FAIL req_hold got %b want 1 (ok=%0b)", spi_request_o, ok); end
    @(negedge clk);
    n_cmp++; if (spi_request_o !== 1'b0) begin n_bad++; $display("FAIL req_clear got %b want 0", spi_request_o); end
    n_cmp++; if (spi_data_o !== 16'h1234) begin n_bad++; $display("FAIL data_stable got %h want 1234", spi_data_o); end
    wait_valid(100, ok);
    @(negedge clk);
    n_cmp++; if (!ok || m_valid_o !== 1'b1) begin n_bad++; $display("FAIL cap_valid got %b want 1 (ok=%0b)", m_valid_o, ok); end
    n_cmp++; if (m_data_o !== 16'hA5C3) begin n_bad++; $display("FAIL cap_data got %h want a5c3", m_data_o); end
    n_cmp++; if (fifo_level_o !== 3'd1) begin n_bad++; $display("FAIL cap_level got %0d want 1", fifo_level_o); end
    @(negedge clk);
    n_cmp++; if (m_valid_o !== 1'b0) begin n_bad++; $display("FAIL pop_valid got %b want 0", m_valid_o); end
    wait_req_rise(200, ok, t2);
    n_cmp++; if (!ok || (t2 - t1) != 100) begin n_bad++; $display("FAIL req_period got %0d want 100 (ok=%0b)", t2 - t1, ok); end
    n_cmp++; if (spi_data_o !== 16'h5678) begin n_bad++; $display("FAIL relatch_data got %h want 5678", spi_data_o); end
  endtask

  task automatic test_missed();
    bit ok;
    int t, misses, rises, drops;
    bit prev;
    wait_valid(200, ok);
    valid_delay = 150;
    wait_req_rise(200, ok, t);
    misses = 0; rises = 0; drops = 0; prev = spi_request_o; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (missed_tick_o) misses++;
      if (dropped_o) drops++;
      if (spi_request_o && !prev) rises++;
      prev = spi_request_o;
      if (spi_valid) begin ok = 1'b1; break; end
    end
    valid_delay = 40;
    repeat (3) begin
      @(negedge clk);
      if (missed_tick_o) misses++;
    end
    n_cmp++; if (!ok || misses != 1) begin n_bad++; $display("FAIL missed_pulses got %0d want 1 (ok=%0b)", misses, ok); end
    n_cmp++; if (rises != 0) begin n_bad++; $display("FAIL missed_no_req got %0d want 0", rises); end
    n_cmp++; if (drops != 0) begin n_bad++; $display("FAIL missed_no_drop got %0d want 0", drops); end
    n_cmp++; if (drop_count_o !== 16'(DropOn)) begin n_bad++; $display("FAIL missed_dcnt got %0d want %0d", drop_count_o, DropOn); end
  endtask

  task automatic test_fifo_full();
    bit ok;
    int drops;
    m_ready = 1'b0; model_inc = 1'b1; set_val = 16'h1000; set_req = ~set_req;
    drops = 0; ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 250; i++) begin
        @(negedge clk);
        if (dropped_o) drops++;
        if (spi_valid) begin got = 1'b1; break; end
      end
      if (!got) ok = 1'b0;
    end
    repeat (2) begin
      @(negedge clk);
      if (dropped_o) drops++;
    end
    n_cmp++; if (!ok || fifo_level_o !== 3'd4) begin n_bad++; $display("FAIL full_level got %0d want 4 (ok=%0b)", fifo_level_o, ok); end
    n_cmp++; if (drops != 2) begin n_bad++; $display("FAIL full_drops got %0d want 2", drops); end
    n_cmp++; if (m_valid_o !== 1'b1 || m_data_o !== 16'h1000) begin n_bad++; $display("FAIL full_head got %b/%h want 1/1000", m_valid_o, m_data_o); end
    n_cmp++; if (drop_count_o !== 16'(3 * DropOn)) begin n_bad++; $display("FAIL full_dcnt got %0d want %0d", drop_count_o, 3 * DropOn); end
  endtask

  task automatic test_full_pop();
    bit ok;
    logic [15:0] exp_q [4];
    exp_q[0] = 16'h1001; exp_q[1] = 16'h1002; exp_q[2] = 16'h1003; exp_q[3] = 16'h1006;
    wait_valid(250, ok);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    n_cmp++; if (!ok || fifo_level_o !== 3'd4) begin n_bad++; $display("FAIL fpop_level got %0d want 4 (ok=%0b)", fifo_level_o, ok); end
    n_cmp++; if (dropped_o !== 1'b0) begin n_bad++; $display("FAIL fpop_nodrop got %b want 0", dropped_o); end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (m_valid_o !== 1'b1 || m_data_o !== exp_q[i]) begin
        n_bad++; $display("FAIL fpop_word%0d got %b/%h want 1/%h", i, m_valid_o, m_data_o, exp_q[i]);
      end
      @(negedge clk);
    end
    n_cmp++; if (fifo_level_o !== 3'd0 || m_valid_o !== 1'b0) begin n_bad++; $display("FAIL fpop_empty got %0d/%b want 0/0", fifo_level_o, m_valid_o); end
  endtask

  task automatic test_reset_busy();
    bit ok;
    int t;
    m_ready = 1'b0; model_inc = 1'b0; set_val = 16'h0BAD; set_req = ~set_req;
    wait_valid(250, ok);
    @(negedge clk);
    n_cmp++; if (!ok || fifo_level_o !== 3'd1) begin n_bad++; $display("FAIL rb_pre_level got %0d want 1 (ok=%0b)", fifo_level_o, ok); end
    wait_req_rise(200, ok, t);
    repeat (10) @(negedge clk);
    n_cmp++; if (!ok || spi_cs_n !== 1'b0) begin n_bad++; $display("FAIL rb_busy got cs_n=%b want 0 (ok=%0b)", spi_cs_n, ok); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if (spi_request_o !== 1'b0) begin n_bad++; $display("FAIL rb_req got %b want 0", spi_request_o); end
    n_cmp++; if (m_valid_o !== 1'b0 || fifo_level_o !== 3'd0) begin n_bad++; $display("FAIL rb_fifo got %b/%0d want 0/0", m_valid_o, fifo_level_o); end
    n_cmp++; if (drop_count_o !== 16'h0) begin n_bad++; $display("FAIL rb_dcnt got %h want 0", drop_count_o); end
    wait_valid(100, ok);
    repeat (2) @(negedge clk);
    n_cmp++; if (!ok || fifo_level_o !== 3'd0 || m_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL rb_late_valid got %0d/%b want 0/0 (ok=%0b)", fifo_level_o, m_valid_o, ok);
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int t, rises;
    bit prev;
    m_ready = 1'b1; set_val = 16'hBEEF; set_req = ~set_req;
    wait_req_rise(200, ok, t);
    @(negedge clk);
    enable = 1'b0;
    wait_valid(100, ok);
    @(negedge clk);
    n_cmp++; if (!ok || m_valid_o !== 1'b1 || m_data_o !== 16'hBEEF) begin
      n_bad++; $display("FAIL en_capture got %b/%h want 1/beef (ok=%0b)", m_valid_o, m_data_o, ok);
    end
    rises = 0; prev = spi_request_o;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (spi_request_o && !prev) rises++;
      prev = spi_request_o;
    end
    n_cmp++; if (rises != 0 || spi_request_o !== 1'b0) begin n_bad++; $display("FAIL en_no_req got %0d rises want 0", rises); end
  endtask

  initial begin : main
    rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0; num_data = 4'hF; tx_data = 16'h1234;
    @(negedge clk);
    test_reset();
    test_basic();
    test_missed();
    test_fifo_full();
    test_full_pop();
    test_reset_busy();
    test_enable_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_sample_sequencer.md
# spi_sample_sequencer

Periodic sampling front-end that sits directly upstream and downstream of `quick_spi`. It issues `quick_spi` requests at a fixed sample rate and captures each word strobed on `quick_spi`'s `data_o`/`data_valid_o`. Captured words are buffered in a small FIFO and presented to the rest of the design as a valid/ready stream. It also detects missed sample ticks and dropped words.

## Interface
- `CLK_FREQ_HZ`, 100000000, system clock frequency.
- `SAMPLE_RATE_HZ`, 1000000, sample tick rate. `PERIOD = CLK_FREQ_HZ/SAMPLE_RATE_HZ`; `PERIOD < 2` is an elaboration error.
- `MAX_DATA_LENGTH`, 16, bits per device per word. Must match the `quick_spi` instance.
- `NUM_DEVICES`, 1, parallel SPI devices. Must match the `quick_spi` instance.
- `FIFO_DEPTH`, 4, capture FIFO entries. Must be a power of 2 and at least 2.
- `clk_i`  in  1  system clock.
- `rst_n_i`  in  1  reset. Synchronous, active-low.
- `enable_i`  in  1  run sampling; low holds the period counter at 0.
- `num_data_i`  in  `$clog2(MAX_DATA_LENGTH)`  bits per transfer. Latched at each tick.
- `tx_data_i`  in  `MAX_DATA_LENGTH*NUM_DEVICES`  command word. Latched at each tick.
- `spi_request_o`  out  1  to `quick_spi` `request_i`.
- `spi_num_data_o`  out  `$clog2(MAX_DATA_LENGTH)`  to `quick_spi` `num_data_i`.
- `spi_data_o`  out  `MAX_DATA_LENGTH*NUM_DEVICES`  to `quick_spi` `data_i`.
- `spi_cs_n_i`  in  1  from `quick_spi` `cs_n_o`; request acknowledge.
- `spi_data_i`  in  `MAX_DATA_LENGTH*NUM_DEVICES`  from `quick_spi` `data_o`.
- `spi_data_valid_i`  in  1  from `quick_spi` `data_valid_o`.
- `m_valid_o`  out  1  stream valid.
- `m_ready_i`  in  1  stream ready.
- `m_data_o`  out  `MAX_DATA_LENGTH*NUM_DEVICES`  stream data (FIFO head).
- `fifo_level_o`  out  `$clog2(FIFO_DEPTH)+1`  FIFO occupancy.
- `missed_tick_o`  out  1  one-cycle pulse when a tick arrives while not IDLE.
- `dropped_o`  out  1  one-cycle pulse when a captured word is discarded because the FIFO is full.
- `drop_count_o`  out  16  saturating count of missed ticks plus dropped words (see Configuration).

## Operation
- Period counter runs 0..`PERIOD-1` while `enable_i` is high. `tick` = counter at `PERIOD-1`; the counter then wraps to 0.
- FSM states:
  - IDLE: on `tick`, latch `num_data_i`/`tx_data_i` into `spi_num_data_o`/`spi_data_o` and go to REQUEST.
  - REQUEST: hold `spi_request_o`=1. When `spi_cs_n_i`==0, clear `spi_request_o` (low on the next cycle) and go to BUSY.
  - BUSY: on `spi_data_valid_i`, write `spi_data_i` to the FIFO if not full, else pulse `dropped_o`. Go to IDLE.
- `tick` in REQUEST or BUSY: pulse `missed_tick_o`; the FSM is unaffected.
- FIFO push and pop in the same cycle: allowed in any state, including full. Level is unchanged.
- `enable_i` falling mid-transaction: the transaction completes and its word is captured. No new tick occurs.
- `spi_data_valid_i` in IDLE or REQUEST: ignored, no push.

## Timing
- Reset values: `spi_request_o` 0, `spi_num_data_o` 0, `spi_data_o` 0, `m_valid_o` 0, `fifo_level_o` 0, `missed_tick_o` 0, `dropped_o` 0, `drop_count_o` 0. FSM resets to IDLE; counter to 0.
- `tick` at cycle N -> `spi_request_o` high at N+1.
- `spi_cs_n_i` low at cycle M -> `spi_request_o` low at M+1.
  - `quick_spi` ignores `request_i` outside WAIT/SAMPLE_STROBE, so the overlap is harmless.
  - `quick_spi` may sit in RESET indefinitely; holding the request covers that.
- `spi_data_valid_i` at cycle K -> `m_valid_o` high at K+1 if the FIFO was empty. `fifo_level_o` updates at K+1.
- Stream handshake: a transfer occurs when `m_valid_o && m_ready_i`. `m_data_o` is stable while `m_valid_o` is high and `m_ready_i` is low.
- Reset asserted mid-operation: all state returns to reset values on the next edge. FIFO contents are discarded.

## Configuration
- `SEQ_DROP_COUNT_EN` defined:
  - `drop_count_o` increments by 1 for each `missed_tick_o` pulse and each `dropped_o` pulse.
  - If both pulse in the same cycle, it increments by 2.
  - Saturates at 16'hFFFF.
- `SEQ_DROP_COUNT_EN` undefined: `drop_count_o` is tied to 0 and no counter register exists. The pulses remain.

## Structure
- Shared package `spi_pkg` holds:
  - the FSM state encoding (IDLE=2'd0, REQUEST=2'd1, BUSY=2'd2);
  - the `PERIOD` computation;
  - the parameter-check macro.
- One sub-module: `sync_fifo`, with parameters WIDTH and DEPTH, show-ahead, and level output. It is instantiated once.

## Test plan
- CLK 100 MHz, SAMPLE 1 MHz, `enable_i`=1; model answers `spi_cs_n_i` low 3 cycles after request, valid 40 cycles later with 16'hA5C3 -> request every 100 cycles, `m_data_o`=16'hA5C3, `m_valid_o` high 1 cycle after valid.
- Model delays `spi_data_valid_i` 150 cycles -> `missed_tick_o` pulses once per overlapped tick, no second request, `drop_count_o`=1 (macro on) / 0 (macro off).
- `m_ready_i`=0 for 6 samples, FIFO_DEPTH=4 -> `fifo_level_o`=4, `dropped_o` pulses twice, head word = first sample.
- FIFO full with `m_ready_i`=1 in the cycle `spi_data_valid_i` arrives -> no drop, level stays 4, new word queued at tail.
- Reset pulsed while in BUSY -> next cycle `spi_request_o`=0, `m_valid_o`=0, level 0. The late `spi_data_valid_i` is ignored.
- `enable_i` dropped one cycle after request -> transfer completes, word captured, no further requests for 300 cycles.
